// File: rtl/qbus_arbiter_pkg.sv
// ============================================================================
// qbus_arbiter_pkg : shared state encodings and default timing constants
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package qbus_arbiter_pkg;

    typedef enum logic [2:0] {
        QB_IDLE  = 3'd0,
        QB_CYC   = 3'd1,
        QB_DONE  = 3'd2,
        QB_GRANT = 3'd3,
        QB_DMA   = 3'd4
    } qb_state_t;

    localparam int QB_BUS_TIMEOUT_DEF = 63;
    localparam int QB_GRANT_WAIT_DEF  = 15;

    // Counter width: enough bits for the larger of the two reload values, plus one.
    function automatic int qb_cnt_w(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qbus_arbiter_if.sv
// ============================================================================
// qbus_arbiter_if : CPU request, Q-bus strobe and DMA handshake bundle
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface qbus_arbiter_if;
    logic cpu_dati;
    logic cpu_dato;
    logic cpu_byte;
    logic cpu_done;
    logic cpu_error;
    logic bsync;
    logic bdin;
    logic bdout;
    logic bwtbt;
    logic bbsy;
    logic breply;
    logic dmr;
    logic dmgo;
    logic sack;

    modport master (
        input  cpu_dati, cpu_dato, cpu_byte, breply, dmr, sack,
        output cpu_done, cpu_error, bsync, bdin, bdout, bwtbt, bbsy, dmgo
    );

    modport slave (
        output cpu_dati, cpu_dato, cpu_byte, breply, dmr, sack,
        input  cpu_done, cpu_error, bsync, bdin, bdout, bwtbt, bbsy, dmgo
    );
endinterface

`default_nettype wire

// File: rtl/qbus_arbiter_watchdog.sv
// ============================================================================
// qbus_arbiter_watchdog : loadable down-counter, saturates at zero
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module qbus_arbiter_watchdog #(
    parameter int WIDTH = 7
) (
    input  wire              clk,
    input  wire              reset_n,
    input  wire              i_ce,
    input  wire              i_load,
    input  wire [WIDTH-1:0]  i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_ce && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/qbus_arbiter.sv
// ============================================================================
// qbus_arbiter : 1801VM1 Q-bus cycle sequencer and CPU/DMA arbiter
// Optional no-reply watchdog enabled by defining QBUS_TIMEOUT_EN.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module qbus_arbiter
    import qbus_arbiter_pkg::*;
#(
    parameter int BUS_TIMEOUT = QB_BUS_TIMEOUT_DEF,
    parameter int GRANT_WAIT  = QB_GRANT_WAIT_DEF
) (
    input  wire             clk,
    input  wire             reset_n,
    input  wire             ce,
    qbus_arbiter_if.master  bus
);

    localparam int c_CNT_W = qb_cnt_w(BUS_TIMEOUT, GRANT_WAIT);
    // Reload is one less than the budget so the entry cycle counts toward it.
    localparam logic [c_CNT_W-1:0] c_GRANT_LOAD = c_CNT_W'(GRANT_WAIT - 1);

    qb_state_t r_state;
    qb_state_t w_next;
    logic      r_rply_s1;
    logic      r_rply_s2;
    logic      r_write;
    logic      r_byte;
    logic      r_done;
    logic      w_load;
    logic      w_grant_zero;
    logic      w_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rply_s1 <= 1'b0;
            r_rply_s2 <= 1'b0;
        end else begin
            r_rply_s1 <= bus.breply;
            r_rply_s2 <= r_rply_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= QB_IDLE;
        end else if (ce) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            QB_IDLE: begin
                if (bus.dmr) begin
                    w_next = QB_GRANT;
                end else if ((bus.cpu_dati || bus.cpu_dato) && !bus.sack) begin
                    w_next = QB_CYC;
                end
            end
            QB_CYC:   if (r_rply_s2 || w_timeout) w_next = QB_DONE;
            QB_DONE:  if (!r_rply_s2) w_next = QB_IDLE;
            QB_GRANT: begin
                if (bus.sack) begin
                    w_next = QB_DMA;
                end else if (!bus.dmr || w_grant_zero) begin
                    w_next = QB_IDLE;
                end
            end
            QB_DMA:   if (!bus.sack) w_next = QB_IDLE;
            default:  w_next = QB_IDLE;
        endcase
    end

    // Read wins when both requests are raised together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write <= 1'b0;
            r_byte  <= 1'b0;
        end else if (ce && (r_state == QB_IDLE) && (w_next == QB_CYC)) begin
            r_write <= bus.cpu_dato && !bus.cpu_dati;
            r_byte  <= bus.cpu_byte;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= 1'b0;
        end else if (ce) begin
            r_done <= (r_state == QB_CYC) && (w_next == QB_DONE);
        end
    end

    assign w_load = ce && (w_next != r_state);

    qbus_arbiter_watchdog #(.WIDTH(c_CNT_W)) u_grant_wd (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_ce       (ce && (r_state == QB_GRANT)),
        .i_load     (w_load),
        .i_load_val (c_GRANT_LOAD),
        .o_zero     (w_grant_zero)
    );

`ifdef QBUS_TIMEOUT_EN
    localparam logic [c_CNT_W-1:0] c_BUS_LOAD = c_CNT_W'(BUS_TIMEOUT - 1);
    logic r_err;

    qbus_arbiter_watchdog #(.WIDTH(c_CNT_W)) u_bus_wd (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_ce       (ce && (r_state == QB_CYC)),
        .i_load     (w_load),
        .i_load_val (c_BUS_LOAD),
        .o_zero     (w_timeout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (ce) begin
            r_err <= (r_state == QB_CYC) && !r_rply_s2 && w_timeout;
        end
    end

    assign bus.cpu_error = r_err;
`else
    assign w_timeout     = 1'b0;
    assign bus.cpu_error = 1'b0;
`endif

    assign bus.cpu_done = r_done;
    assign bus.bsync    = (r_state == QB_CYC);
    assign bus.bdin     = (r_state == QB_CYC) && !r_write;
    assign bus.bdout    = (r_state == QB_CYC) && r_write;
    assign bus.bwtbt    = (r_state == QB_CYC) && r_byte;
    assign bus.bbsy     = (r_state == QB_CYC) || (r_state == QB_DONE);
    assign bus.dmgo     = (r_state == QB_GRANT);

endmodule

`default_nettype wire
